apb_reg_bank: RTL and testbench

- APB slave register bank. Sits directly downstream of the AXI-lite→APB converter and consumes its APB master port through the apb_ifc.slave modport.
- Provides N_CTRL byte-strobed RW control registers, one read-only hardware status register, and a W1C interrupt status/enable pair driving a level irq output.
- Supports programmable wait states and returns pslverr on illegal accesses.

---
 rtl/apb_reg_bank_pkg.sv | 41 ++++
 rtl/apb_ifc.sv | 26 ++
 rtl/apb_wait_ctr.sv | 33 +++
 rtl/apb_reg_bank.sv | 198 +++++++++++++++++++
 tb/tb_apb_reg_bank.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_reg_bank_pkg.sv
// Shared constants, types and helpers for the APB register bank.
package apb_reg_bank_pkg;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int CNT_W = 4;

  localparam logic [7:0] CTRL_BASE    = 8'h00;
  localparam logic [7:0] STATUS_OFS   = 8'h40;
  localparam logic [7:0] IRQ_STAT_OFS = 8'h44;
  localparam logic [7:0] IRQ_EN_OFS   = 8'h48;

  // Slave-side view of the transfer; lags the bus phase by one cycle.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Register targeted by the transfer, decoded once at setup time.
  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_STATUS,
    REG_IRQ_STAT,
    REG_IRQ_EN
  } reg_sel_e;

  // Byte-lane merge: lanes with a strobe take wdata, others keep old.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] wdata,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int k = 0; k < SW; k++) begin
      if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_ifc.sv
// APB bus bundle shared by the converter (master) and register bank (slave).
interface apb_ifc #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states; done while the count is zero.
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         pclk_i,
  input  logic         presetn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank: CTRL RW registers, live STATUS, W1C IRQ pair.
//
// state  | meaning
// IDLE   | no transfer; outputs held at zero
// SETUP  | setup seen last cycle; decode and wait count latched
// ACCESS | access phase; pready once the wait count reaches zero
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int          AW_APB      = 32,
  parameter int          DW_APB      = 32,
  parameter int          N_CTRL      = 4,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] CTRL_RST    = 32'h0
) (
  input  logic                     pclk,
  input  logic                     presetn,
  apb_ifc.slave                    apb,
  input  logic [DW_APB-1:0]        hw_status,
  input  logic [DW_APB-1:0]        hw_event,
  output logic [N_CTRL*DW_APB-1:0] ctrl_o,
  output logic                     irq
);

  if (DW_APB != 32) begin : g_bad_dw
    $error("apb_reg_bank: DW_APB must be 32");
  end
  if (N_CTRL < 1 || N_CTRL > 16) begin : g_bad_nctrl
    $error("apb_reg_bank: N_CTRL must be 1..16");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("apb_reg_bank: WAIT_STATES must be 0..15");
  end

  apb_state_e        state_q, state_d;
  reg_sel_e          region_q, region_d;
  logic [3:0]        idx_q, idx_d;
  logic              wr_q;
  logic              load, done, pready_s, legal, commit;
  logic [7:0]        ofs;
  logic [DW_APB-1:0] rdata;
  logic [DW_APB-1:0] ctrl_q [N_CTRL];
  logic [DW_APB-1:0] ctrl_d [N_CTRL];
  logic [DW_APB-1:0] irq_stat_q, irq_stat_d;
  logic [DW_APB-1:0] irq_en_q, irq_en_d;
  logic [DW_APB-1:0] clr_mask;
  logic              irq_q;
  logic              unused_apb;

  // Upper address bits and protection attributes carry no meaning here.
  assign unused_apb = ^{apb.pprot, apb.paddr[AW_APB-1:8]};

  // Every setup phase restarts the wait count and re-decodes the address.
  assign load = apb.psel && !apb.penable;

  apb_wait_ctr #(.W(CNT_W)) u_wait_ctr (
    .pclk_i     (pclk),
    .presetn_i  (presetn),
    .load_i     (load),
    .load_val_i (CNT_W'(WAIT_STATES)),
    .dec_i      (state_q == ACCESS),
    .done_o     (done)
  );

  // Address decode; a write to STATUS decodes as unmapped.
  always_comb begin
    region_d = REG_NONE;
    idx_d    = '0;
    ofs      = apb.paddr[7:0];
    if (ofs[1:0] == 2'b00) begin
      if (ofs < STATUS_OFS) begin
        if (int'(ofs[5:2]) < N_CTRL) begin
          region_d = REG_CTRL;
          idx_d    = ofs[5:2] - CTRL_BASE[5:2];
        end
      end else if (ofs == STATUS_OFS) begin
        if (!apb.pwrite) region_d = REG_STATUS;
      end else if (ofs == IRQ_STAT_OFS) begin
        region_d = REG_IRQ_STAT;
      end else if (ofs == IRQ_EN_OFS) begin
        region_d = REG_IRQ_EN;
      end
    end
  end

  // FSM state register and latched transfer decode.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        region_q <= region_d;
        idx_q    <= idx_d;
        wr_q     <= apb.pwrite;
      end
    end
  end

  // FSM next state; losing psel mid-transfer abandons it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) state_d = SETUP;
      end
      SETUP: begin
        if (!apb.psel)        state_d = IDLE;
        else if (apb.penable) state_d = ACCESS;
        else                  state_d = SETUP;
      end
      ACCESS: begin
        if (!apb.psel)         state_d = IDLE;
        else if (!apb.penable) state_d = SETUP;
        else if (done)         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pready_s = (state_q == ACCESS) && done;
  assign legal    = (region_q != REG_NONE);
  assign commit   = apb.psel && apb.penable && pready_s && wr_q && legal;

  // Read mux over the latched target.
  always_comb begin
    rdata = '0;
    case (region_q)
      REG_CTRL: begin
        for (int i = 0; i < N_CTRL; i++) begin
          if (idx_q == 4'(i)) rdata = ctrl_q[i];
        end
      end
      REG_STATUS:   rdata = hw_status;
      REG_IRQ_STAT: rdata = irq_stat_q;
      REG_IRQ_EN:   rdata = irq_en_q;
      default:      rdata = '0;
    endcase
  end

  // FSM outputs; prdata is forced to zero outside a successful read.
  always_comb begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (pready_s) begin
      apb.pready = 1'b1;
      if (!legal)     apb.pslverr = 1'b1;
      else if (!wr_q) apb.prdata  = rdata;
    end
  end

  // Register next-state: strobed writes, W1C clear with event set winning.
  always_comb begin
    for (int i = 0; i < N_CTRL; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (commit && region_q == REG_CTRL && idx_q == 4'(i)) begin
        ctrl_d[i] = apply_strb(ctrl_q[i], apb.pwdata, apb.pstrb);
      end
    end
    irq_en_d = irq_en_q;
    if (commit && region_q == REG_IRQ_EN) begin
      irq_en_d = apply_strb(irq_en_q, apb.pwdata, apb.pstrb);
    end
    clr_mask = '0;
    if (commit && region_q == REG_IRQ_STAT) begin
      clr_mask = apply_strb('0, apb.pwdata, apb.pstrb);
    end
    irq_stat_d = (irq_stat_q & ~clr_mask) | hw_event;
  end

  // Register storage and the registered interrupt line.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= CTRL_RST;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  // Flatten CTRL registers onto the output bus.
  always_comb begin
    ctrl_o = '0;
    for (int i = 0; i < N_CTRL; i++) ctrl_o[i*DW_APB +: DW_APB] = ctrl_q[i];
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench: one bank with no wait states, one with three.
module tb_apb_reg_bank;

  localparam logic [31:0] RST3 = 32'h5A5A_0F0F;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, hw_status = '0, hw_event = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, sel = 1'b0;
  logic [3:0]  pstrb = '0;

  logic [127:0] ctrl0, ctrl3;
  logic         irq0, irq3;
  logic         pready_m, pslverr_m;
  logic [31:0]  prdata_m;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0]  r;
  logic         e, lk;
  int           w;
  logic [127:0] snap;

  always #5 pclk = ~pclk;

  apb_ifc #(.AW(32), .DW(32)) bus0 ();
  apb_ifc #(.AW(32), .DW(32)) bus3 ();

  assign bus0.paddr   = paddr;
  assign bus0.psel    = psel & ~sel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus0.pprot   = 3'b000;
  assign bus3.paddr   = paddr;
  assign bus3.psel    = psel & sel;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;
  assign bus3.pprot   = 3'b010;

  assign pready_m  = sel ? bus3.pready  : bus0.pready;
  assign prdata_m  = sel ? bus3.prdata  : bus0.prdata;
  assign pslverr_m = sel ? bus3.pslverr : bus0.pslverr;

  apb_reg_bank #(
    .AW_APB(32), .DW_APB(32), .N_CTRL(4), .WAIT_STATES(0), .CTRL_RST(32'h0)
  ) u_dut0 (
    .pclk(pclk), .presetn(presetn), .apb(bus0), .hw_status(hw_status),
    .hw_event(hw_event), .ctrl_o(ctrl0), .irq(irq0)
  );

  apb_reg_bank #(
    .AW_APB(32), .DW_APB(32), .N_CTRL(4), .WAIT_STATES(3), .CTRL_RST(RST3)
  ) u_dut3 (
    .pclk(pclk), .presetn(presetn), .apb(bus3), .hw_status(hw_status),
    .hw_event(hw_event), .ctrl_o(ctrl3), .irq(irq3)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1. ev is driven during the completing cycle.
  task automatic xfer(input logic [31:0] a, input logic wr_en, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] ev,
                      output logic [31:0] rd_val, output logic err,
                      output int waits, output logic leak);
    logic done;
    paddr = a; pwrite = wr_en; pwdata = d; pstrb = s;
    psel = 1'b1; penable = 1'b0;
    waits = 0; leak = 1'b0; rd_val = '0; err = 1'b0; done = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (pready_m) begin
        done = 1'b1; rd_val = prdata_m; err = pslverr_m; hw_event = ev;
      end else begin
        waits++;
        if (prdata_m != 0 || pslverr_m) leak = 1'b1;
      end
    end
    chk("xfer_done", done, 1'b1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; hw_event = '0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic exp_err);
    xfer(a, 1'b1, d, s, 32'h0, r, e, w, lk);
    chk({tag, "_err"}, e, exp_err);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic exp_err);
    xfer(a, 1'b0, 32'h0, 4'hF, 32'h0, r, e, w, lk);
    chk({tag, "_data"}, r, exp_d);
    chk({tag, "_err"}, e, exp_err);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    // Reset values
    cycles(2);
    @(negedge pclk);
    chk("rst_pready", pready_m, 1'b0);
    chk("rst_prdata", prdata_m, 32'h0);
    chk("rst_pslverr", pslverr_m, 1'b0);
    chk("rst_ctrl0", ctrl0, 128'h0);
    chk("rst_ctrl3", ctrl3, {4{RST3}});
    chk("rst_irq", irq0, 1'b0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    cycles(1);

    // No wait states: one SETUP cycle, then pready in first ACCESS cycle
    sel = 1'b0;
    xfer(32'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, r, e, w, lk);
    chk("w04_err", e, 1'b0);
    chk("w04_waits", w, 1);
    chk("w04_ctrl1", ctrl0[63:32], 32'hDEAD_BEEF);
    xfer(32'h04, 1'b0, 32'h0, 4'hF, 32'h0, r, e, w, lk);
    chk("r04_data", r, 32'hDEAD_BEEF);
    chk("r04_err", e, 1'b0);
    chk("r04_waits", w, 1);

    // Partial strobe
    wr("w00_full", 32'h00, 32'h1122_3344, 4'hF, 1'b0);
    wr("w00_part", 32'h00, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd("r00_part", 32'h00, 32'h11BB_33DD, 1'b0);
    chk("part_ctrl0", ctrl0[31:0], 32'h11BB_33DD);

    // Three wait states on STATUS read; high-address bits ignored
    sel = 1'b1;
    hw_status = 32'h0000_A5A5;
    xfer(32'hFF00_0040, 1'b0, 32'h0, 4'hF, 32'h0, r, e, w, lk);
    chk("st_data", r, 32'h0000_A5A5);
    chk("st_err", e, 1'b0);
    chk("st_waits", w, 4);
    chk("st_leak", lk, 1'b0);
    @(negedge pclk);
    chk("st_pready_drop", pready_m, 1'b0);
    chk("st_prdata_drop", prdata_m, 32'h0);
    @(posedge pclk); #1;

    // Illegal accesses
    sel = 1'b0;
    snap = ctrl0;
    rd("e4c", 32'h4C, 32'h0, 1'b1);
    wr("e40", 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd("e02r", 32'h02, 32'h0, 1'b1);
    wr("e02w", 32'h02, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("e10w", 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd("e10r", 32'h10, 32'h0, 1'b1);
    wr("w08_nostrb", 32'h08, 32'hFFFF_FFFF, 4'h0, 1'b0);
    chk("err_noside", ctrl0, snap);
    rd("en_untouched", 32'h48, 32'h0, 1'b0);

    // Interrupts
    wr("wen", 32'h48, 32'h1, 4'hF, 1'b0);
    hw_event = 32'h1;
    @(posedge pclk); #1;
    hw_event = 32'h0;
    @(negedge pclk);
    chk("irq_lag", irq0, 1'b0);
    @(posedge pclk);
    @(negedge pclk);
    chk("irq_set", irq0, 1'b1);
    @(posedge pclk); #1;
    xfer(32'h44, 1'b1, 32'h1, 4'hF, 32'h1, r, e, w, lk);
    chk("w1c_race_err", e, 1'b0);
    cycles(1);
    @(negedge pclk);
    chk("irq_race_hold", irq0, 1'b1);
    @(posedge pclk); #1;
    rd("stat_race", 32'h44, 32'h1, 1'b0);
    wr("w1c", 32'h44, 32'h1, 4'hF, 1'b0);
    @(negedge pclk);
    chk("irq_clr_lag", irq0, 1'b1);
    @(posedge pclk);
    @(negedge pclk);
    chk("irq_clr", irq0, 1'b0);
    @(posedge pclk); #1;
    hw_event = 32'h2;
    @(posedge pclk); #1;
    hw_event = 32'h0;
    cycles(2);
    chk("irq_masked", irq0, 1'b0);
    rd("stat_b1", 32'h44, 32'h2, 1'b0);
    wr("w1c_nolane", 32'h44, 32'hFF, 4'hE, 1'b0);
    rd("stat_b1_kept", 32'h44, 32'h2, 1'b0);
    wr("w1c_b1", 32'h44, 32'hFF, 4'hF, 1'b0);
    rd("stat_empty", 32'h44, 32'h0, 1'b0);

    // Reset during a wait state of a write
    sel = 1'b1;
    wr("w3_00", 32'h00, 32'h1234_5678, 4'hF, 1'b0);
    chk("w3_ctrl0", ctrl3[31:0], 32'h1234_5678);
    paddr = 32'h00; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    chk("mid_wait_pready", pready_m, 1'b0);
    presetn = 1'b0;
    #1;
    chk("mid_rst_ctrl0", ctrl3[31:0], RST3);
    chk("mid_rst_pready", pready_m, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    cycles(2);
    chk("post_rst_ctrl0", ctrl3[31:0], RST3);

    // Back-to-back transfers
    xfer(32'h04, 1'b1, 32'h0BAD_CAFE, 4'hF, 32'h0, r, e, w, lk);
    chk("b2b_w_err", e, 1'b0);
    chk("b2b_w_waits", w, 4);
    xfer(32'h04, 1'b0, 32'h0, 4'hF, 32'h0, r, e, w, lk);
    chk("b2b_r_data", r, 32'h0BAD_CAFE);
    chk("b2b_r_waits", w, 4);
    wr("b2b_w08", 32'h08, 32'h1357_9BDF, 4'hF, 1'b0);
    rd("b2b_r08", 32'h08, 32'h1357_9BDF, 1'b0);

    // psel dropped during wait states: transfer abandoned
    paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", pready_m, 1'b0);
    cycles(6);
    chk("abort_noside", ctrl3[63:32], 32'h0BAD_CAFE);
    rd("abort_recover", 32'h04, 32'h0BAD_CAFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
